// File: rtl/sram_slave_pkg.sv
// Shared configuration for the SRAM slave block.
//   DepthDefault   : default number of 32-bit words in the array
//   LatencyDefault : default cycles from request acceptance to ready
//   state_e        : request-servicing FSM states
//   req_t          : one captured request (address, write data, byte strobes)
package sram_slave_pkg;

    localparam int unsigned DepthDefault   = 4096;
    localparam int unsigned LatencyDefault = 1;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/sram_array.sv
// Word-organised storage for the SRAM slave. Writes happen on the rising
// edge with per-byte enables. The read port is combinational on the same
// address, so a read sees every write completed on an earlier edge.
// Contents are deliberately not reset.
//   clk   : clock
//   we    : byte-lane write enables (bit i writes wdata[8i+7:8i])
//   addr  : word index
//   wdata : write data
//   rdata : word currently stored at addr
module sram_array
    import sram_slave_pkg::*;
#(
    parameter int unsigned depth = DepthDefault
) (
    input  logic                       clk,
    input  logic [3:0]                 we,
    input  logic [$clog2(depth)-1:0]   addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    logic [31:0] mem [depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_slave.sv
// Single-port SRAM slave with fixed response latency. One request is in
// service at a time and one more can wait in a pending buffer; anything
// arriving while both are occupied is dropped. Each accepted request gets
// exactly one sram_ready pulse, in acceptance order.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   sram_valid : single-cycle request strobe
//   sram_instr : fetch qualifier, no functional effect
//   sram_addr  : byte offset within the block
//   sram_wdata : write data
//   sram_wstrb : byte write enables, 0000 = read
//   sram_rdata : read data, non-zero only during a read completion
//   sram_ready : single-cycle completion strobe
module sram_slave
    import sram_slave_pkg::*;
#(
    parameter int unsigned depth   = DepthDefault,
    parameter int unsigned latency = LatencyDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_valid,
    input  logic        sram_instr,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    input  logic [3:0]  sram_wstrb,
    output logic [31:0] sram_rdata,
    output logic        sram_ready
);

    localparam int unsigned AddrWidth = $clog2(depth);
    localparam logic [3:0]  CntLoad   = 4'(latency - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        cur_q, cur_d;
    req_t        pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;

    req_t        in_req;
    logic        done;
    logic        in_range;
    logic [3:0]  array_we;
    logic [31:0] array_rdata;
    logic        unused_ok;

    assign in_req = '{addr: sram_addr, wdata: sram_wdata, wstrb: sram_wstrb};

    // Completion cycle: the current request finishes at the end of this cycle.
    assign done = (state_q == StBusy) && (cnt_q == 4'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        case (state_q)
            StIdle: begin
                if (sram_valid) begin
                    cur_d   = in_req;
                    cnt_d   = CntLoad;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    // Capture into the pending slot if free, otherwise drop.
                    if (sram_valid && !pend_vld_q) begin
                        pend_d     = in_req;
                        pend_vld_d = 1'b1;
                    end
                end else if (pend_vld_q) begin
                    // Older pending request goes first; a new request arriving
                    // now takes the slot it just vacated.
                    cur_d = pend_q;
                    cnt_d = CntLoad;
                    if (sram_valid) begin
                        pend_d = in_req;
                    end else begin
                        pend_vld_d = 1'b0;
                    end
                end else if (sram_valid) begin
                    cur_d = in_req;
                    cnt_d = CntLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and array control
    // ------------------------------------------------------------------
    always_comb begin
        in_range   = (cur_q.addr[31:AddrWidth+2] == '0);
        sram_ready = done;
        array_we   = (done && in_range) ? cur_q.wstrb : 4'b0000;
        sram_rdata = '0;
        if (done && in_range && (cur_q.wstrb == 4'b0000)) begin
            sram_rdata = array_rdata;
        end
    end

    sram_array #(
        .depth (depth)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (cur_q.addr[AddrWidth+1:2]),
        .wdata (cur_q.wdata),
        .rdata (array_rdata)
    );

    // Byte offset within a word and the fetch qualifier carry no function.
    assign unused_ok = ^{sram_instr, cur_q.addr[1:0]};

endmodule

// File: tb/tb_sram_slave.sv
// Directed bench for sram_slave: four instances with latency 1..4 share the
// request buses; each has its own valid strobe and response outputs.
module tb_sram_slave;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  ready;
    logic [31:0] rdata [4];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_slave #(
            .depth   (4096),
            .latency (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sram_valid (valid[g]),
            .sram_instr (instr),
            .sram_addr  (addr),
            .sram_wdata (wdata),
            .sram_wstrb (wstrb),
            .sram_rdata (rdata[g]),
            .sram_ready (ready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rdata must be zero whenever ready is low.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ready[k] !== 1'b1) begin
                check($sformatf("idle_rdata_dut%0d", k), rdata[k], 32'h0);
            end
        end
    end

    // Issue one request on instance k and wait (bounded) for its ready.
    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output int lat, output logic [31:0] rd);
        addr     = a;
        wdata    = wd;
        wstrb    = ws;
        valid[k] = 1'b1;
        tick();
        valid[k] = 1'b0;
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        for (int c = 1; c <= 20; c++) begin
            if (ready[k] === 1'b1) begin
                lat = c;
                rd  = rdata[k];
                tick();
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vec [21];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [9:0]  mask;

        vec[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
        vec[1]  = '{0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
        vec[2]  = '{0, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0000_0000};
        vec[3]  = '{0, 32'h0000_0020, 32'h0000_AA00, 4'b0010, 32'h0000_0000};
        vec[4]  = '{0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h1122_AA44};
        vec[5]  = '{0, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000};
        vec[6]  = '{0, 32'h0000_4000, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vec[7]  = '{0, 32'h0000_4000, 32'h0000_0055, 4'b1111, 32'h0000_0000};
        vec[8]  = '{0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D};
        vec[9]  = '{0, 32'h0000_0013, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
        vec[10] = '{0, 32'h0000_3FFC, 32'hA5A5_A5A5, 4'b1111, 32'h0000_0000};
        vec[11] = '{0, 32'h0000_3FFE, 32'h0000_0000, 4'b0000, 32'hA5A5_A5A5};
        vec[12] = '{0, 32'h0000_0020, 32'h7700_0000, 4'b1000, 32'h0000_0000};
        vec[13] = '{0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h7722_AA44};
        vec[14] = '{1, 32'h0000_0004, 32'h0102_0304, 4'b1111, 32'h0000_0000};
        vec[15] = '{1, 32'h0000_0004, 32'h0000_0000, 4'b0000, 32'h0102_0304};
        vec[16] = '{2, 32'h0000_0040, 32'h1234_5678, 4'b1111, 32'h0000_0000};
        vec[17] = '{2, 32'h0000_0040, 32'h0000_0000, 4'b0000, 32'h1234_5678};
        vec[18] = '{3, 32'h0000_0080, 32'h0BAD_F00D, 4'b1111, 32'h0000_0000};
        vec[19] = '{3, 32'h0000_0080, 32'h0000_0000, 4'b0000, 32'h0BAD_F00D};
        vec[20] = '{0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000};

        rst   = 1'b1;
        valid = 4'b0000;
        instr = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        repeat (3) tick();
        check("reset_ready", {28'h0, ready}, 32'h0);
        check("reset_rdata0", rdata[0], 32'h0);
        rst = 1'b0;

        // Table of single requests; latency is the instance index plus one.
        for (int i = 0; i < 21; i++) begin
            instr = i[0];
            do_req(vec[i].dut, vec[i].addr, vec[i].wdata, vec[i].wstrb, lat, rd);
            check($sformatf("vec%0d_latency", i), lat, vec[i].dut + 1);
            check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
        end
        instr = 1'b0;

        // Latency 3, valids in cycles 0,1,2: readys at 3 and 6, third dropped.
        addr  = 32'h0000_0040;
        wstrb = 4'b0000;
        mask  = '0;
        for (int c = 0; c < 10; c++) begin
            valid[2] = (c < 3);
            if (ready[2] === 1'b1) begin
                mask[c] = 1'b1;
                check($sformatf("pend_rdata_c%0d", c), rdata[2], 32'h1234_5678);
            end
            tick();
        end
        valid[2] = 1'b0;
        check("pend_ready_mask", {22'h0, mask}, 32'h0000_0048);

        // Latency 2, valids in cycles 0 and 2: readys at 2 and 4.
        addr = 32'h0000_0004;
        mask = '0;
        for (int c = 0; c < 8; c++) begin
            valid[1] = (c == 0) || (c == 2);
            if (ready[1] === 1'b1) begin
                mask[c] = 1'b1;
            end
            tick();
        end
        valid[1] = 1'b0;
        check("b2b_ready_mask", {22'h0, mask}, 32'h0000_0014);

        // Reset while a latency-4 write is in flight; latency-1 read shows the
        // asynchronous clear of ready/rdata.
        addr     = 32'h0000_0080;
        wdata    = 32'hFFFF_FFFF;
        wstrb    = 4'b1111;
        valid[3] = 1'b1;
        tick();
        valid[3] = 1'b0;
        addr     = 32'h0000_0010;
        wstrb    = 4'b0000;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        check("pre_rst_ready0", {31'h0, ready[0]}, 32'h1);
        check("pre_rst_rdata0", rdata[0], 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready0", {31'h0, ready[0]}, 32'h0);
        check("async_rst_rdata0", rdata[0], 32'h0);
        tick();
        tick();
        rst  = 1'b0;
        mask = '0;
        for (int c = 0; c < 8; c++) begin
            if (ready[3] === 1'b1) begin
                mask[c] = 1'b1;
            end
            tick();
        end
        check("rst_no_ready", {22'h0, mask}, 32'h0);
        do_req(3, 32'h0000_0080, 32'h0, 4'b0000, lat, rd);
        check("rst_read_latency", lat, 4);
        check("rst_write_discarded", rd, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_slave.md
SRAM_SLAVE -- requirements
Module: sram_slave

Interface
REQ-001 Parameter depth: default 4096; number of 32-bit words, power of two, 16..65536.
REQ-002 Parameter latency: default 1; cycles from request acceptance to ready, 1..15.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sram_valid  input  1  single-cycle request strobe.
REQ-007 sram_instr  input  1  fetch qualifier; accepted, no functional effect.
REQ-008 sram_addr  input  32  byte offset within block (base already removed upstream).
REQ-009 sram_wdata  input  32  write data.
REQ-010 sram_wstrb  input  4  byte-lane write enables; 0000 = read.
REQ-011 sram_rdata  output  32  response data, valid only while sram_ready=1.
REQ-012 sram_ready  output  1  single-cycle completion strobe, one per accepted request.

Function
REQ-013 FSM states IDLE, BUSY; one request in service, plus one-entry pending buffer.
REQ-014 IDLE with valid=1: latch addr/wdata/wstrb, load counter = latency-1, go BUSY.
REQ-015 BUSY: counter decrements each cycle; at counter=0, assert ready for exactly one cycle and complete request.
REQ-016 Latency: ready asserted exactly latency cycles after the valid cycle (latency=1 -> next cycle).
REQ-017 Word index = sram_addr[log2(depth)+1:2]; sram_addr[1:0] ignored.
REQ-018 Out of range (sram_addr >= 4*depth): read returns 0, write discarded, ready still pulses with normal latency.
REQ-019 Read: rdata = stored word at index, sampled at completion cycle (sees all earlier completed writes).
REQ-020 Write: lanes with wstrb[i]=1 updated at completion edge; other lanes unchanged; rdata=0 during write ready.
REQ-021 valid in same cycle as ready: accepted as new request, next ready latency cycles later (back-to-back, no bubble).
REQ-022 valid during BUSY, not in ready cycle: captured in pending buffer if empty; serviced immediately after current completion, its ready exactly latency cycles after the current ready.
REQ-023 valid during BUSY with pending buffer full: request dropped, no ready generated for it.
REQ-024 Requests complete strictly in acceptance order.
REQ-025 sram_ready=0 and sram_rdata=0 in every cycle outside a completion cycle.

Reset
REQ-026 rst=1: state IDLE, counter 0, pending empty, sram_ready=0, sram_rdata=0, immediately (asynchronous).
REQ-027 Reset mid-operation: in-flight and pending requests discarded; no ready after release; their writes not performed.
REQ-028 Memory contents not reset; preserved across reset.
REQ-029 First request accepted on first rising edge with rst=0.

Structure
REQ-030 Defaults for depth and latency held as constants in the shared configure package.
REQ-031 Storage in sub-module sram_array: synchronous single-port word array with per-byte write enables; FSM, counter, pending buffer in sram_slave.

Verification
REQ-032 latency=1, write 0xDEADBEEF to addr 0x10 wstrb 1111, then read 0x10 -> ready one cycle after each valid; read rdata=0xDEADBEEF.
REQ-033 Partial write: word 0x11223344 at 0x20, write 0x0000AA00 wstrb 0010, read -> 0x1122AA44.
REQ-034 latency=3, valid at cycles 0,1,2 -> readys at cycles 3 and 6 only; third request dropped.
REQ-035 Back-to-back: latency=2, valids at cycles 0 and 2 -> readys at cycles 2 and 4.
REQ-036 depth=4096, read at 0x4000 -> ready with rdata=0; write 0x55 to 0x4000 then read 0x0 -> data unchanged.
REQ-037 Assert rst one cycle after a write valid (latency=4) -> no ready; read of that address afterwards returns prior content.
